// File: rtl/servo_move_scheduler.sv
// servo_move_scheduler
// Round-robin scheduler that lets exactly one servo valve move at a time.
// A granted move waits for a PWM frame boundary, then drives the new position
// onto set_bit and holds the channel for SETTLE_FRAMES frames.
// After that the requester gets a one-cycle ack.
// Requests whose target already matches set_bit are acknowledged with no frame wait.
module servo_move_scheduler #(
    parameter int NCH           = 4,
    parameter int SETTLE_FRAMES = 25,
    parameter int CNT_W         = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           frame_tick,
    input  logic [NCH-1:0] req,
    input  logic [NCH-1:0] pos,
    output logic [NCH-1:0] ack,
    output logic [NCH-1:0] set_bit,
    output logic [NCH-1:0] move_en,
    output logic           busy
);

    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_FRAMES - 1);
    localparam logic [NCH-1:0]   ONE      = NCH'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ALIGN  = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state;
    logic [GW-1:0]    rr;
    logic [GW-1:0]    g;
    logic             g_pos;
    logic [CNT_W-1:0] cnt;

    logic             found;
    logic [GW-1:0]    pick;

    // Channel index following ch, wrapping at NCH (NCH need not be a power of two)
    function automatic logic [GW-1:0] next_ch(input logic [GW-1:0] ch);
        if (ch == GW'(NCH - 1)) begin
            return '0;
        end
        return ch + GW'(1);
    endfunction

    // Find the first requesting channel at or after the round-robin pointer
    always_comb begin : grant_search
        int j;
        j     = 0;
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NCH; i++) begin
            j = int'(rr) + i;
            if (j >= NCH) begin
                j = j - NCH;
            end
            if (!found && req[j]) begin
                found = 1'b1;
                pick  = GW'(j);
            end
        end
    end

    // Scheduler FSM; every output is a register so the servo interfaces see clean levels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rr      <= '0;
            g       <= '0;
            g_pos   <= 1'b0;
            cnt     <= '0;
            ack     <= '0;
            set_bit <= '0;
            move_en <= '0;
            busy    <= 1'b0;
        end else begin
            // ack is a single-cycle pulse: only the edge entering DONE sets it
            ack <= '0;
            case (state)
                IDLE: begin
                    // frame_tick is deliberately ignored here; only req matters
                    if (found) begin
                        g     <= pick;
                        g_pos <= pos[pick];
                        busy  <= 1'b1;
                        if (pos[pick] == set_bit[pick]) begin
                            // Already at target: acknowledge without touching the servo
                            ack   <= ONE << pick;
                            state <= DONE;
                        end else begin
                            state <= ALIGN;
                        end
                    end
                end
                ALIGN: begin
                    // Change the commanded position only on a frame boundary
                    if (frame_tick) begin
                        set_bit[g] <= g_pos;
                        cnt        <= CNT_INIT;
                        move_en    <= ONE << g;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (frame_tick) begin
                        if (cnt == '0) begin
                            ack   <= ONE << g;
                            state <= DONE;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    move_en <= '0;
                    busy    <= 1'b0;
                    rr      <= next_ch(g);
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_servo_move_scheduler.sv
// Directed testbench for servo_move_scheduler (NCH=4, SETTLE_FRAMES=3).
// Inputs change on the falling edge and outputs are sampled there too,
// so every check sees the state produced by the preceding rising edge.
module tb_servo_move_scheduler;

    localparam int NCH = 4;

    logic           clk;
    logic           rst_n;
    logic           frame_tick;
    logic [NCH-1:0] req;
    logic [NCH-1:0] pos;
    logic [NCH-1:0] ack;
    logic [NCH-1:0] set_bit;
    logic [NCH-1:0] move_en;
    logic           busy;

    int checks;
    int errors;

    servo_move_scheduler #(
        .NCH          (NCH),
        .SETTLE_FRAMES(3),
        .CNT_W        (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .frame_tick(frame_tick),
        .req       (req),
        .pos       (pos),
        .ack       (ack),
        .set_bit   (set_bit),
        .move_en   (move_en),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive frame_tick for one rising edge and move on to the next falling edge
    task automatic cyc(input logic tk);
        frame_tick = tk;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req = '0;
        pos = '0;
        frame_tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Expects channel ch to be granted on the next edge and to make a real move
    task automatic grant_and_move(input int ch, input logic [NCH-1:0] exp_set);
        logic [NCH-1:0] oh;
        oh = 4'b0001 << ch;
        cyc(1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL grant_busy ch%0d: got %b want 1", ch, busy); end
        cyc(1'b0);
        cyc(1'b1);
        checks++; if (move_en !== oh) begin errors++; $display("FAIL move_en ch%0d: got %b want %b", ch, move_en, oh); end
        checks++; if (set_bit !== exp_set) begin errors++; $display("FAIL set_bit ch%0d: got %b want %b", ch, set_bit, exp_set); end
        for (int t = 0; t < 2; t++) begin
            cyc(1'b0);
            cyc(1'b1);
            checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL early_ack ch%0d: got %b want 0000", ch, ack); end
        end
        cyc(1'b0);
        cyc(1'b1);
        checks++; if (ack !== oh) begin errors++; $display("FAIL ack ch%0d: got %b want %b", ch, ack, oh); end
        req[ch] = 1'b0;
        cyc(1'b0);
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL ack_clear ch%0d: got %b want 0000", ch, ack); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_clear ch%0d: got %b want 0", ch, busy); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 4'($urandom);
        pos = 4'($urandom);
        frame_tick = 1'b1;
        #1;
        checks++; if (set_bit !== 4'b0000) begin errors++; $display("FAIL rst_set_bit: got %b want 0000", set_bit); end
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL rst_ack: got %b want 0000", ack); end
        checks++; if (move_en !== 4'b0000) begin errors++; $display("FAIL rst_move_en: got %b want 0000", move_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        @(negedge clk);
        @(negedge clk);
        req = '0;
        pos = '0;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(i[0]);
            checks++; if ({set_bit, ack, move_en, busy} !== 13'd0) begin errors++; $display("FAIL post_rst_idle: got %b want 0", {set_bit, ack, move_en, busy}); end
        end
    endtask

    task automatic test_single_move();
        apply_reset();
        req = 4'b0100;
        pos = 4'b0100;
        cyc(1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
        for (int i = 0; i < 8; i++) cyc(1'b0);
        checks++; if (set_bit !== 4'b0000) begin errors++; $display("FAIL single_pre_tick: got %b want 0000", set_bit); end
        cyc(1'b1);
        checks++; if (set_bit !== 4'b0100) begin errors++; $display("FAIL single_set_bit: got %b want 0100", set_bit); end
        checks++; if (move_en !== 4'b0100) begin errors++; $display("FAIL single_move_en: got %b want 0100", move_en); end
        for (int t = 1; t <= 3; t++) begin
            for (int i = 0; i < 9; i++) cyc(1'b0);
            checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL single_ack_gap%0d: got %b want 0000", t, ack); end
            cyc(1'b1);
            if (t < 3) begin
                checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL single_early_ack%0d: got %b want 0000", t, ack); end
            end
        end
        checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL single_ack: got %b want 0100", ack); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_in_done: got %b want 1", busy); end
        req = 4'b0000;
        cyc(1'b0);
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL single_ack_once: got %b want 0000", ack); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall: got %b want 0", busy); end
        checks++; if (move_en !== 4'b0000) begin errors++; $display("FAIL single_move_en_clr: got %b want 0000", move_en); end
        checks++; if (set_bit !== 4'b0100) begin errors++; $display("FAIL single_set_hold: got %b want 0100", set_bit); end
    endtask

    task automatic test_no_move();
        apply_reset();
        req = 4'b0001;
        pos = 4'b0000;
        cyc(1'b0);
        checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL nomove_ack: got %b want 0001", ack); end
        checks++; if (move_en !== 4'b0000) begin errors++; $display("FAIL nomove_move_en: got %b want 0000", move_en); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nomove_busy: got %b want 1", busy); end
        req = 4'b0000;
        cyc(1'b0);
        checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL nomove_ack_once: got %b want 0000", ack); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nomove_busy_fall: got %b want 0", busy); end
        checks++; if (set_bit !== 4'b0000) begin errors++; $display("FAIL nomove_set_bit: got %b want 0000", set_bit); end
    endtask

    task automatic test_round_robin();
        apply_reset();
        req = 4'b1011;
        pos = 4'b1111;
        grant_and_move(0, 4'b0001);
        grant_and_move(1, 4'b0011);
        grant_and_move(3, 4'b1011);
        checks++; if (set_bit !== 4'b1011) begin errors++; $display("FAIL rr_set_bit: got %b want 1011", set_bit); end
        req = 4'b1001;
        pos = 4'b0000;
        grant_and_move(0, 4'b1010);
        grant_and_move(3, 4'b0010);
        // Pointer wrapped to 0 after channel 3: channel 0 must win over channel 1
        req = 4'b0011;
        pos = 4'b0011;
        grant_and_move(0, 4'b0011);
        cyc(1'b0);
        checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL rr_nomove_ch1: got %b want 0010", ack); end
        req = 4'b0000;
        cyc(1'b0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_settle();
        apply_reset();
        req = 4'b0010;
        pos = 4'b0010;
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b1);
        checks++; if (set_bit !== 4'b0010) begin errors++; $display("FAIL midrst_moved: got %b want 0010", set_bit); end
        cyc(1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (set_bit !== 4'b0000) begin errors++; $display("FAIL midrst_set_bit: got %b want 0000", set_bit); end
        checks++; if (move_en !== 4'b0000) begin errors++; $display("FAIL midrst_move_en: got %b want 0000", move_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1);
            checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL midrst_no_ack: got %b want 0000", ack); end
        end
        rst_n = 1'b1;
        grant_and_move(1, 4'b0010);
    endtask

    task automatic test_drop_in_align();
        int acks;
        acks = 0;
        req = 4'b1000;
        pos = 4'b1000;
        cyc(1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drop_grant: got %b want 1", busy); end
        req = 4'b0000;
        pos = 4'b0000;
        cyc(1'b0);
        cyc(1'b1);
        checks++; if (set_bit !== 4'b1010) begin errors++; $display("FAIL drop_set_bit: got %b want 1010", set_bit); end
        checks++; if (move_en !== 4'b1000) begin errors++; $display("FAIL drop_move_en: got %b want 1000", move_en); end
        for (int i = 0; i < 12; i++) begin
            cyc(i[0]);
            if (ack == 4'b1000) acks++;
        end
        checks++; if (acks !== 1) begin errors++; $display("FAIL drop_ack_count: got %0d want 1", acks); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_no_regrant: got %b want 0", busy); end
        checks++; if (set_bit !== 4'b1010) begin errors++; $display("FAIL drop_final_set: got %b want 1010", set_bit); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        req = '0;
        pos = '0;
        frame_tick = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_move();
        test_no_move();
        test_round_robin();
        test_reset_mid_settle();
        test_drop_in_align();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/servo_move_scheduler.md
# servo_move_scheduler

Schedules servo valve moves in the microfluidic flow controller. Only one servo may be in motion at a time because of supply-current limits. Each valve channel raises a move request with a target position. The block grants requests round-robin and drives the registered `set_bit` level that feeds each channel's servo PWM interface. Every position change is aligned to a 20 ms PWM frame boundary. The channel is held for a settle interval before the requester is acknowledged.

## Interface
- `NCH`, 4, number of servo/valve channels (2..16)
- `SETTLE_FRAMES`, 25, PWM frames a moved servo is given to settle (≥1; 25 = 500 ms)
- `CNT_W`, 8, settle counter width; must hold `SETTLE_FRAMES-1`

Ports:
- `clk`  in  1  system clock (100 MHz)
- `rst_n`  in  1  asynchronous, active-low reset
- `frame_tick`  in  1  one-cycle pulse per PWM frame, from the PWM counter wrap
- `req`  in  NCH  per-channel move request, level, held until `ack`
- `pos`  in  NCH  per-channel target position (0 = closed, 1 = open), valid while `req` is high
- `ack`  out  NCH  one-cycle completion pulse to the granted channel
- `set_bit`  out  NCH  registered commanded position per channel, to the servo interfaces
- `move_en`  out  NCH  one-hot, the channel currently moving/settling
- `busy`  out  1  high in any state other than IDLE

## Operation
- State machine: IDLE, ALIGN, SETTLE, DONE.
- **IDLE**
  - If any `req` bit is high, choose grant `g`: the first requesting channel at or after round-robin pointer `rr`, searching upward modulo NCH.
  - Latch `g` and `pos[g]`.
  - If `pos[g] == set_bit[g]`, go to DONE (no-move request; no frame wait). Otherwise go to ALIGN.
  - `frame_tick` is ignored in IDLE.
- **ALIGN**
  - Wait for `frame_tick`.
  - On the tick: `set_bit[g] <= latched pos`, `cnt <= SETTLE_FRAMES-1`, `move_en[g] <= 1`, go to SETTLE.
- **SETTLE**
  - On each `frame_tick`: if `cnt == 0`, go to DONE; else decrement `cnt`.
- **DONE**
  - `ack[g] = 1` for exactly this cycle.
  - `move_en <= 0`; `rr <= (g+1) mod NCH`; go to IDLE.
- Requests are sampled only at grant.
  - Dropping `req` or changing `pos` after grant has no effect: the move completes and `ack` still pulses.
- A requester must drop `req` in its `ack` cycle. A `req` still high in the following IDLE cycle is a new request, arbitrated with the updated `rr`.
- Ungranted channels' `set_bit` never change.
- `set_bit` changes only on the ALIGN→SETTLE transition, so PWM duty changes at a frame boundary.

## Timing
- Reset (async assert, sync deassert from `clk`):
  - `set_bit` = 0 (all closed); `ack` = 0; `move_en` = 0; `busy` = 0.
  - `rr` = 0; state = IDLE; `cnt` = 0.
- Reset mid-operation: all outputs go to reset values immediately and no `ack` is issued. The interrupted requester re-requests.
- Grant latency: `req` high at edge k (IDLE) gives `busy` high after edge k.
- No-move path: state DONE after edge k, so `ack` is high between edges k and k+1.
- Move path:
  - ALIGN consumes the first `frame_tick` sampled after edge k. `set_bit` and `move_en` update on that edge.
  - After that, `SETTLE_FRAMES` further ticks are counted. DONE is entered on the edge sampling the `SETTLE_FRAMES`-th tick, and `ack` is high for the following cycle.
- Back-to-back: IDLE occupies at least one cycle between grants, so the minimum spacing from `ack` to the next grant is 1 cycle.
- A `frame_tick` coincident with the DONE or IDLE cycle is not counted toward the next move.

## Test plan
- **Reset.** Assert `rst_n`=0 with random `req`/`pos`.
  - Required: `set_bit`=0, `ack`=0, `move_en`=0, `busy`=0.
  - After release with no `req`, outputs stay 0.
- **Single move.** `SETTLE_FRAMES`=3, `frame_tick` every 10 cycles, `req[2]`=1, `pos[2]`=1.
  - `set_bit[2]` and `move_en[2]` rise on the first tick edge.
  - `ack[2]` is a single cycle right after the 3rd subsequent tick.
  - `busy` falls one cycle later.
- **No-move.** After reset, `req[0]`=1, `pos[0]`=0.
  - `ack[0]` is high for 1 cycle, the cycle after the request is sampled, with no tick required.
  - `set_bit` is unchanged and `move_en` never asserts.
- **Round-robin.**
  - `req`=4'b1011 simultaneously, all `pos`=1: grants in order 0, 1, 3, each with a full settle; `set_bit`=4'b1011.
  - Then `req`=4'b1001 with `pos`=0: grant order 0, then 3 (`rr`=0 after 3).
- **Reset mid-SETTLE.** Pull `rst_n` low during SETTLE of channel 1.
  - `set_bit[1]` returns to 0 asynchronously and no `ack` is issued.
  - Re-request after release completes normally.
- **Request dropped during ALIGN.** `req[3]` falls before the aligning tick.
  - The move still completes: `set_bit[3]`=`pos` and `ack[3]` pulses once.
  - No second grant occurs.
